// File: rtl/code_loader.sv
// Byte-stream code loader: packs 3 little-endian bytes per 18-bit word, writes N words
// into code memory, and holds the processor in reset until the load completes.
//
// state | meaning
// IDLE  | waiting for start, processor held in reset
// HDR   | collecting the 3-byte word count N
// DATA  | collecting the 3 bytes of the next code word
// WRITE | one-cycle code memory write strobe
// DONE  | load finished, processor released
// ERROR | load aborted on a format error, processor held
module code_loader #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18,
  parameter int MEM_SIZE  = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 code_we,
  output logic [ADDR_SIZE-1:0] code_addr,
  output logic [WORD_SIZE-1:0] code_din,
  output logic                 processor_reset,
  output logic                 complete_fill_ram,
  output logic                 load_error
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERROR} state_t;

  state_t                 state_q;
  logic [1:0]             byte_idx_q;
  logic [7:0]             byte0_q;
  logic [7:0]             byte1_q;
  logic [WORD_SIZE-1:0]   count_q;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [WORD_SIZE-1:0]   din_q;
  logic                   in_ready_q;
  logic                   we_q;
  logic                   proc_rst_q;
  logic                   done_q;
  logic                   err_q;

  logic                   accept;
  logic                   fmt_err;
  logic                   last_word;
  logic [WORD_SIZE-1:0]   word_d;

  assign accept    = in_valid && in_ready_q;
  assign fmt_err   = |in_data[7:2];
  assign word_d    = WORD_SIZE'({in_data[1:0], byte1_q, byte0_q});
  assign last_word = (WORD_SIZE'(addr_q) == (count_q - WORD_SIZE'(1)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      byte_idx_q <= 2'd0;
      byte0_q    <= 8'd0;
      byte1_q    <= 8'd0;
      count_q    <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      proc_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_q    <= HDR;
            byte_idx_q <= 2'd0;
            addr_q     <= '0;
            in_ready_q <= 1'b1;
            proc_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        HDR, DATA: begin
          if (accept) begin
            case (byte_idx_q)
              2'd0: begin
                byte0_q    <= in_data;
                byte_idx_q <= 2'd1;
              end
              2'd1: begin
                byte1_q    <= in_data;
                byte_idx_q <= 2'd2;
              end
              default: begin
                byte_idx_q <= 2'd0;
                if (fmt_err) begin
                  state_q    <= ERROR;
                  in_ready_q <= 1'b0;
                  err_q      <= 1'b1;
                end else if (state_q == HDR) begin
                  count_q <= word_d;
                  if (word_d == '0) begin
                    state_q    <= DONE;
                    in_ready_q <= 1'b0;
                    proc_rst_q <= 1'b0;
                    done_q     <= 1'b1;
                  end else if (word_d > WORD_SIZE'(MEM_SIZE)) begin
                    state_q    <= ERROR;
                    in_ready_q <= 1'b0;
                    err_q      <= 1'b1;
                  end else begin
                    state_q <= DATA;
                  end
                end else begin
                  din_q      <= word_d;
                  we_q       <= 1'b1;
                  in_ready_q <= 1'b0;
                  state_q    <= WRITE;
                end
              end
            endcase
          end
        end
        WRITE: begin
          we_q <= 1'b0;
          if (last_word) begin
            state_q    <= DONE;
            proc_rst_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            // N never exceeds MEM_SIZE, so the increment stays within memory
            addr_q     <= addr_q + ADDR_SIZE'(1);
            in_ready_q <= 1'b1;
            state_q    <= DATA;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          we_q       <= 1'b0;
          proc_rst_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready          = in_ready_q;
  assign code_we           = we_q;
  assign code_addr         = addr_q;
  assign code_din          = din_q;
  assign processor_reset   = proc_rst_q;
  assign complete_fill_ram = done_q;
  assign load_error        = err_q;

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: expected writes are queued as bytes are driven
// and matched against every code_we pulse by a negedge monitor.
module tb_code_loader;
  localparam int AW = 18;
  localparam int WW = 18;
  localparam int MS = 1024;

  logic          clock;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          code_we;
  logic [AW-1:0] code_addr;
  logic [WW-1:0] code_din;
  logic          processor_reset;
  logic          complete_fill_ram;
  logic          load_error;

  int vectors;
  int miscompares;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  logic prev_we;

  code_loader #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .MEM_SIZE(MS)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .code_we(code_we),
    .code_addr(code_addr),
    .code_din(code_din),
    .processor_reset(processor_reset),
    .complete_fill_ram(complete_fill_ram),
    .load_error(load_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // every write strobe must match the head of the expected-write queue
  always @(negedge clock) begin
    if (code_we) begin
      wr_t e;
      vectors++;
      if (prev_we) begin
        miscompares++;
        $display("FAIL we_width: code_we high for consecutive cycles at addr %0d", code_addr);
      end
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: addr %0d data %05h, required no write", code_addr, code_din);
      end else begin
        e = exp_q.pop_front();
        if (code_addr !== e.addr || code_din !== e.data) begin
          miscompares++;
          $display("FAIL write: got addr %0d data %05h, required addr %0d data %05h",
                   code_addr, code_din, e.addr, e.data);
        end
      end
    end
    prev_we = code_we;
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    start    = with_start;
    for (int n = 0; n < 50 && !ok; n++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clock); #1;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL send_byte: byte %02h not accepted within bound, in_ready=%b", b, in_ready);
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic send_word(input logic [17:0] w, input int gap, input bit push, input int addr);
    wr_t e;
    if (push) begin
      e.addr = AW'(addr);
      e.data = w;
      exp_q.push_back(e);
    end
    send_byte(w[7:0], gap, 1'b0);
    send_byte(w[15:8], gap, 1'b0);
    send_byte({6'd0, w[17:16]}, gap, 1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (complete_fill_ram || load_error) ok = 1'b1;
      else begin @(posedge clock); #1; end
    end
    vectors++;
    if (!complete_fill_ram || load_error || processor_reset) begin
      miscompares++;
      $display("FAIL %s_done: complete=%b error=%b preset=%b, required 1 0 0",
               name, complete_fill_ram, load_error, processor_reset);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing: %0d expected writes not seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (in_ready !== 1'b0 || code_we !== 1'b0 || code_addr !== '0 || code_din !== '0 ||
        processor_reset !== 1'b1 || complete_fill_ram !== 1'b0 || load_error !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: rdy=%b we=%b addr=%0d din=%05h preset=%b done=%b err=%b, required 0 0 0 00000 1 0 0",
               name, in_ready, code_we, code_addr, code_din, processor_reset,
               complete_fill_ram, load_error);
    end
  endtask

  task automatic test_reset();
    check_reset_outputs("reset_state");
    reset = 1'b1;
    idle_cycles(3);
    check_reset_outputs("idle_after_release");
  endtask

  task automatic test_idle_bytes();
    in_valid = 1'b1;
    in_data  = 8'h02;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_ready: in_ready=%b, required 0", in_ready);
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_normal();
    pulse_start();
    send_word(18'd2, 0, 1'b0, 0);
    send_word(18'h00001, 0, 1'b1, 0);
    send_word(18'h3FFFF, 0, 1'b1, 1);
    wait_done("normal");
  endtask

  task automatic test_restart();
    pulse_start();
    vectors++;
    if (processor_reset !== 1'b1 || complete_fill_ram !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL restart: preset=%b done=%b rdy=%b, required 1 0 1",
               processor_reset, complete_fill_ram, in_ready);
    end
    send_word(18'd1, 0, 1'b0, 0);
    send_word(18'h2ABCD, 0, 1'b1, 0);
    wait_done("restart");
  endtask

  task automatic test_stalled();
    pulse_start();
    send_word(18'd2, 3, 1'b0, 0);
    send_word(18'h00001, 3, 1'b1, 0);
    send_word(18'h3FFFF, 3, 1'b1, 1);
    wait_done("stalled");
  endtask

  task automatic test_empty();
    pulse_start();
    send_word(18'd0, 0, 1'b0, 0);
    vectors++;
    if (complete_fill_ram !== 1'b1 || processor_reset !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL empty: done=%b preset=%b rdy=%b, required 1 0 0",
               complete_fill_ram, processor_reset, in_ready);
    end
    idle_cycles(3);
  endtask

  task automatic test_err_count();
    pulse_start();
    send_word(18'd1025, 0, 1'b0, 0);
    vectors++;
    if (load_error !== 1'b1 || processor_reset !== 1'b1 || in_ready !== 1'b0 ||
        complete_fill_ram !== 1'b0) begin
      miscompares++;
      $display("FAIL err_count: err=%b preset=%b rdy=%b done=%b, required 1 1 0 0",
               load_error, processor_reset, in_ready, complete_fill_ram);
    end
    idle_cycles(4);
  endtask

  task automatic test_err_byte2();
    pulse_start();
    send_word(18'd1, 0, 1'b0, 0);
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    send_byte(8'h04, 0, 1'b0);
    vectors++;
    if (load_error !== 1'b1 || processor_reset !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL err_byte2: err=%b preset=%b rdy=%b, required 1 1 0",
               load_error, processor_reset, in_ready);
    end
    idle_cycles(4);
  endtask

  task automatic test_start_ignored();
    wr_t e;
    pulse_start();
    send_word(18'd2, 0, 1'b0, 0);
    e.addr = AW'(0);
    e.data = 18'h15A3C;
    exp_q.push_back(e);
    send_byte(8'h3C, 0, 1'b1);
    send_byte(8'h5A, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    pulse_start();
    send_word(18'h0BEEF, 0, 1'b1, 1);
    wait_done("start_ignored");
  endtask

  task automatic test_reset_midload();
    pulse_start();
    send_word(18'd2, 0, 1'b0, 0);
    send_word(18'h12345, 0, 1'b1, 0);
    send_byte(8'h77, 0, 1'b0);
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_midload");
    idle_cycles(2);
    reset = 1'b1;
    idle_cycles(3);
    check_reset_outputs("reset_midload_idle");
    pulse_start();
    send_word(18'd2, 0, 1'b0, 0);
    send_word(18'h0A0A0, 0, 1'b1, 0);
    send_word(18'h30303, 0, 1'b1, 1);
    wait_done("reload");
  endtask

  task automatic test_full_depth();
    pulse_start();
    send_word(18'(MS), 0, 1'b0, 0);
    for (int i = 0; i < MS; i++) begin
      send_word(18'(i) ^ 18'h2A5A5, 0, 1'b1, i);
    end
    wait_done("full_depth");
    vectors++;
    if (code_addr !== AW'(MS - 1)) begin
      miscompares++;
      $display("FAIL full_depth_addr: code_addr=%0d, required %0d", code_addr, MS - 1);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    prev_we     = 1'b0;
    reset       = 1'b0;
    start       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    #22;
    test_reset();
    test_idle_bytes();
    test_normal();
    test_restart();
    test_stalled();
    test_empty();
    test_err_count();
    test_err_byte2();
    test_start_ignored();
    test_reset_midload();
    test_full_depth();
    idle_cycles(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/code_loader.md
CODE_LOADER -- requirements
Module: code_loader

Interface
REQ-001 Parameters SHALL be: ADDR_SIZE, default 18, code address width; WORD_SIZE, default 18, code word width (fixed at 18 for the byte packing); MEM_SIZE, default 1024, code memory depth in words.
REQ-002 Port clock SHALL be: input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 Port reset SHALL be: input, 1 bit, asynchronous, active-low; reset==0 forces the reset state immediately.
REQ-004 Port start SHALL be: input, 1 bit, single-cycle pulse that begins a load.
REQ-005 Port in_valid SHALL be: input, 1 bit, in_data holds a valid byte.
REQ-006 Port in_data SHALL be: input, 8 bits, stream byte.
REQ-007 Port in_ready SHALL be: output, 1 bit, loader accepts a byte this cycle.
REQ-008 Port code_we SHALL be: output, 1 bit, code memory write strobe.
REQ-009 Port code_addr SHALL be: output, ADDR_SIZE bits, code memory write address.
REQ-010 Port code_din SHALL be: output, WORD_SIZE bits, code memory write data.
REQ-011 Port processor_reset SHALL be: output, 1 bit, active-high hold for the processor.
REQ-012 Port complete_fill_ram SHALL be: output, 1 bit, load finished successfully.
REQ-013 Port load_error SHALL be: output, 1 bit, load aborted on a format error.

Function
REQ-014 Byte handshake: a byte SHALL be consumed only on a rising edge where in_valid && in_ready.
REQ-015 States SHALL be IDLE, HDR, DATA, WRITE, DONE and ERROR.
REQ-016 Word packing: 3 bytes per word, little-endian; byte0 -> bits[7:0], byte1 -> bits[15:8], byte2[1:0] -> bits[17:16].
REQ-017 Any byte2 with bits[7:2] != 0 SHALL move the loader to ERROR on the accepting edge.
REQ-018 IDLE: in_ready=0 and processor_reset=1; start=1 SHALL move to HDR, clear the byte index and clear code_addr.
REQ-019 HDR: in_ready=1; it SHALL collect one packed word as the word count N.
REQ-020 N==0 SHALL move the loader to DONE on the edge accepting the third header byte.
REQ-021 N>MEM_SIZE SHALL move the loader to ERROR on that same edge.
REQ-022 Any other N SHALL move the loader to DATA on that edge.
REQ-023 DATA: in_ready=1; when the third byte of a word is accepted, the loader SHALL register code_din and move to WRITE.
REQ-024 WRITE: code_we=1 for exactly one cycle with in_ready=0, code_addr=word index and code_din=the packed word.
REQ-025 On leaving WRITE, the loader SHALL go to DONE if the word index equals N-1; otherwise it SHALL increment code_addr by 1 and return to DATA.
REQ-026 Throughput: at most one word per 4 cycles (3 accept cycles plus 1 write cycle); in_valid gaps SHALL only stall, never corrupt, byte assembly.
REQ-027 code_we SHALL be 0 in every state except WRITE; code_addr and code_din SHALL hold their values outside WRITE.
REQ-028 processor_reset SHALL be 1 in every state except DONE.
REQ-029 DONE: processor_reset=0, complete_fill_ram=1, in_ready=0.
REQ-030 ERROR: load_error=1, processor_reset=1, in_ready=0.
REQ-031 start in DONE or ERROR SHALL restart exactly as from IDLE: go to HDR, clear complete_fill_ram and load_error, assert processor_reset.
REQ-032 start in HDR, DATA or WRITE SHALL be ignored.
REQ-033 start coinciding with an accepted byte in HDR or DATA SHALL have the byte accepted and the start ignored.
REQ-034 Bytes presented in IDLE, DONE or ERROR SHALL not be consumed (in_ready=0).
REQ-035 code_addr SHALL never exceed MEM_SIZE-1; a write SHALL never be issued beyond word N-1.

Reset
REQ-036 reset==0 SHALL asynchronously set: state IDLE, in_ready=0, code_we=0, code_addr=0, code_din=0, processor_reset=1, complete_fill_ram=0, load_error=0, byte index=0, N=0.
REQ-037 reset asserted mid-load SHALL abort the load with no further code_we; the words already written SHALL not be rewritten.
REQ-038 After reset release, the loader SHALL stay in IDLE until start.

Verification
REQ-039 Normal load: start, then bytes 02 00 00, 01 00 00, FF FF 03 with in_valid continuously high -> exactly two code_we pulses (addr 0 data 0x00001, addr 1 data 0x3FFFF); then processor_reset=0 and complete_fill_ram=1.
REQ-040 Stalled stream: the same stream with in_valid low for 3 cycles between every byte -> identical writes and values; no code_we during stalls.
REQ-041 Empty load: start, then 00 00 00 -> no code_we; DONE reached on the third header byte's accepting edge.
REQ-042 Format errors: header count 1025 with MEM_SIZE=1024 -> load_error=1 and no writes; separately, a data byte2 of 0x04 -> load_error=1, processor_reset=1, the word not written.
REQ-043 Reset mid-load: reset=0 after 4 of 6 data bytes -> outputs at reset values immediately; after release and a new start, a full reload succeeds from addr 0.
REQ-044 Restart: start in DONE -> processor_reset returns to 1 on the next edge and a second load overwrites addr 0.
